// File: rtl/rr_arbiter8_if.sv
// rr_arbiter8_if: request/grant bundle between eight requesters and the round-robin arbiter.
//   req     [7:0]  request vector, bit i = requester i wants the resource
//   done           current owner releases the resource
//   gnt     [7:0]  one-hot grant (registered)
//   gnt_id  [2:0]  index of the granted requester (registered)
//   busy           a grant is active
//   timeout        one-cycle pulse after a watchdog forced release
// Modports: master = requester side, slave = arbiter side.
interface rr_arbiter8_if;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       busy;
    logic       timeout;

    modport master (
        output req,
        output done,
        input  gnt,
        input  gnt_id,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output gnt,
        output gnt_id,
        output busy,
        output timeout
    );
endinterface

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: round-robin arbiter sharing one resource among eight requesters.
// Grants are held until the owner asserts done, drops its request, or the hold watchdog
// expires after MAX_HOLD cycles. Exactly one idle cycle separates consecutive grants.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    rr_arbiter8_if.slave (req/done in, gnt/gnt_id/busy/timeout out, all registered)
// Parameters:
//   MAX_HOLD  maximum grant length in cycles, 1..(2^CNT_W - 1)
//   CNT_W     hold counter width
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 15,
    parameter int unsigned CNT_W    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    rr_arbiter8_if.slave        bus
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    localparam logic [CNT_W-1:0] HoldLast = CNT_W'(MAX_HOLD - 1);

    state_e           state_q;
    logic [7:0]       gnt_q;
    logic [2:0]       gnt_id_q;
    logic             busy_q;
    logic             timeout_q;
    logic [2:0]       last_q;
    logic [CNT_W-1:0] hc_q;

    logic             pick_vld;
    logic [2:0]       pick_idx;

    // Scan last+1 .. last+8 (mod 8); the final candidate is last itself, so a lone
    // requester that just held the grant can be re-granted.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = last_q;
        for (int k = 1; k <= 8; k++) begin
            logic [2:0] idx;
            idx = last_q + 3'(k);
            if (!pick_vld && bus.req[idx]) begin
                pick_vld = 1'b1;
                pick_idx = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            gnt_q     <= 8'h00;
            gnt_id_q  <= 3'd0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            last_q    <= 3'd7;
            hc_q      <= '0;
        end else begin
            timeout_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pick_vld) begin
                        gnt_q    <= 8'h01 << pick_idx;
                        gnt_id_q <= pick_idx;
                        busy_q   <= 1'b1;
                        last_q   <= pick_idx;
                        hc_q     <= '0;
                        state_q  <= StGrant;
                    end
                end
                StGrant: begin
                    // Voluntary release beats the watchdog so a done on the last
                    // allowed cycle is not reported as a timeout.
                    if (bus.done || !bus.req[gnt_id_q]) begin
                        gnt_q   <= 8'h00;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else if (hc_q == HoldLast) begin
                        gnt_q     <= 8'h00;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                        state_q   <= StIdle;
                    end else begin
                        hc_q <= hc_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_id  = gnt_id_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed self-checking bench for rr_arbiter8 with MAX_HOLD = 4.
// Inputs change and outputs are checked 1 ns after each rising edge.
module tb_rr_arbiter8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;

    rr_arbiter8_if bus ();

    rr_arbiter8 #(
        .MAX_HOLD (4),
        .CNT_W    (4)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [7:0] gnt, input logic [2:0] id,
                             input logic busy, input logic tmo);
        check_eq({tag, ".gnt"},     32'(bus.gnt),     32'(gnt));
        check_eq({tag, ".gnt_id"},  32'(bus.gnt_id),  32'(id));
        check_eq({tag, ".busy"},    32'(bus.busy),    32'(busy));
        check_eq({tag, ".timeout"}, 32'(bus.timeout), 32'(tmo));
    endtask

    // Pulse reset between edges; leaves the bench 1 ns after an edge once done.
    task automatic apply_reset();
        rst_n = 1'b0;
        #2;
        check_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        bus.req  = 8'h00;
        bus.done = 1'b0;
        #2;
        check_out("por", 8'h00, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Single request, done in the 3rd grant cycle, one idle cycle, then re-grant.
        bus.req = 8'h01;
        tick();
        check_out("single.c1", 8'h01, 3'd0, 1'b1, 1'b0);
        tick();
        check_out("single.c2", 8'h01, 3'd0, 1'b1, 1'b0);
        tick();
        check_out("single.c3", 8'h01, 3'd0, 1'b1, 1'b0);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        check_out("single.rel", 8'h00, 3'd0, 1'b0, 1'b0);
        tick();
        check_out("single.regrant", 8'h01, 3'd0, 1'b1, 1'b0);
        bus.req = 8'h00;
        tick();
        check_out("single.drop", 8'h00, 3'd0, 1'b0, 1'b0);

        // Fairness: all requesting, done in each 2nd grant cycle; 0..7 then wrap to 0.
        apply_reset();
        bus.req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            logic [2:0] id;
            id = 3'(i % 8);
            tick();
            check_out($sformatf("rr%0d.c1", i), 8'h01 << id, id, 1'b1, 1'b0);
            tick();
            check_out($sformatf("rr%0d.c2", i), 8'h01 << id, id, 1'b1, 1'b0);
            bus.done = 1'b1;
            tick();
            bus.done = 1'b0;
            check_out($sformatf("rr%0d.idle", i), 8'h00, id, 1'b0, 1'b0);
        end
        bus.req = 8'h00;
        tick();

        // Skip and wrap: set last = 5, then req = 0001_0001 -> 0, 4, 0.
        apply_reset();
        bus.req = 8'h20;
        tick();
        check_out("skip.setup", 8'h20, 3'd5, 1'b1, 1'b0);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        bus.req  = 8'h11;
        tick();
        check_out("skip.g0", 8'h01, 3'd0, 1'b1, 1'b0);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        tick();
        check_out("skip.g4", 8'h10, 3'd4, 1'b1, 1'b0);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        tick();
        check_out("skip.g0b", 8'h01, 3'd0, 1'b1, 1'b0);
        bus.req = 8'h00;
        tick();
        check_out("skip.drop", 8'h00, 3'd0, 1'b0, 1'b0);

        // Watchdog: 4 cycles held, timeout pulse with gnt = 0, re-grant after one idle cycle.
        bus.req = 8'h08;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check_out($sformatf("wd.c%0d", c), 8'h08, 3'd3, 1'b1, 1'b0);
        end
        tick();
        check_out("wd.force", 8'h00, 3'd3, 1'b0, 1'b1);
        tick();
        check_out("wd.regrant", 8'h08, 3'd3, 1'b1, 1'b0);

        // done on the last allowed cycle wins over the watchdog.
        tick();
        tick();
        tick();
        check_out("prio.c4", 8'h08, 3'd3, 1'b1, 1'b0);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        check_out("prio.done", 8'h00, 3'd3, 1'b0, 1'b0);
        bus.req = 8'h00;
        tick();
        check_out("prio.idle", 8'h00, 3'd3, 1'b0, 1'b0);

        // Owner drops its request mid-grant; other bits changing are ignored.
        bus.req = 8'h08;
        tick();
        check_out("drop.grant", 8'h08, 3'd3, 1'b1, 1'b0);
        bus.req = 8'h80;
        tick();
        check_out("drop.rel", 8'h00, 3'd3, 1'b0, 1'b0);
        bus.req = 8'h00;
        tick();

        // Reset mid-grant clears outputs at once; first grant after reset goes to 0.
        bus.req = 8'h20;
        tick();
        check_out("rst.grant", 8'h20, 3'd5, 1'b1, 1'b0);
        bus.req = 8'hFF;
        #2;
        rst_n = 1'b0;
        #1;
        check_out("rst.async", 8'h00, 3'd0, 1'b0, 1'b0);
        #1;
        rst_n = 1'b1;
        tick();
        check_out("rst.first", 8'h01, 3'd0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Round-robin arbiter that shares one 8-input encoded resource among eight requesters. Each cycle it is idle, it picks one pending requester in round-robin order. It drives a one-hot grant plus the matching 3-bit index (encoder-compatible: index = position of the single set grant bit) and holds the grant until release. A hold-time watchdog forces release so no requester can starve the others.

## Interface
Parameters:
- MAX_HOLD, default 15: maximum number of cycles a grant may be held; legal range 1..(2^CNT_W - 1).
- CNT_W, default 4: width of the hold counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  reset. Asynchronous and active-low.
- req  input  8  request vector; bit i = requester i wants the resource.
- done  input  1  the current owner releases the resource; sampled only in GRANT.
- gnt  output  8  one-hot grant, registered; all-zero when no grant.
- gnt_id  output  3  binary index of the granted requester, registered; holds the last value when idle.
- busy  output  1  high while a grant is active (equals |gnt).
- timeout  output  1  one-cycle pulse when a grant is force-released by the watchdog.

## Operation
- States: IDLE and GRANT.
- Internal state: `last[2:0]`, the last-granted index, and hold counter `hc[CNT_W-1:0]`.
- Reset values (rst_n low, asynchronous):
  - state = IDLE, gnt = 8'h00, gnt_id = 3'd0, busy = 0, timeout = 0.
  - last = 3'd7, so requester 0 has first priority after reset; hc = 0.
- IDLE:
  - If req == 0, stay in IDLE.
  - Otherwise, scan indices (last+1), (last+2), ... modulo 8, and select the first i with req[i] = 1.
  - At the clock edge: gnt <= 1<<i, gnt_id <= i, busy <= 1, last <= i, hc <= 0, state <= GRANT.
  - Wrap-around: with last = 7 the scan starts at 0; with last = 6 the order is 7, 0, 1, ...
  - If only requester `last` is requesting, it is re-granted; the scan includes it as the final candidate.
- GRANT: at each edge, evaluate the release conditions in this priority order.
  1. done = 1: release, timeout stays 0.
  2. req[gnt_id] = 0 (requester dropped its request): release, timeout stays 0.
  3. hc == MAX_HOLD-1: forced release, timeout <= 1 for exactly one cycle.
  4. Otherwise: hc <= hc + 1, and the grant is held.
- Release action: gnt <= 0, busy <= 0, state <= IDLE; gnt_id and last keep their values.
- Changes on req bits other than gnt_id during GRANT are ignored; no preemption.
- done in IDLE is ignored.
- timeout is 0 in every cycle except the cycle following a forced release.
- Reset asserted mid-grant: gnt clears immediately (asynchronously) and last returns to 7. The grant in progress is not resumed.

## Timing
- Grant latency: req is sampled at edge k; gnt and gnt_id are valid from edge k (visible in cycle k+1).
- Release latency: done is sampled at edge m; gnt = 0 from edge m. The owner must treat the resource as lost after edge m.
- Minimum gap: exactly one IDLE cycle separates consecutive grants, so back-to-back throughput is one grant per (hold + 1) cycles.
- Maximum hold: MAX_HOLD cycles of gnt high, then one IDLE cycle.
- Worst-case wait for a continuously requesting requester: 7 × (MAX_HOLD + 1) cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Single request: after reset, req = 8'h01 held and done pulsed in the 3rd grant cycle.
  - Expect gnt = 8'h01, gnt_id = 0, busy = 1 for 3 cycles, then gnt = 8'h00 for 1 cycle.
- Round-robin fairness: req = 8'hFF held, done pulsed every 2nd grant cycle.
  - Expect gnt_id sequence 0,1,2,...,7,0 (wrap-around), each grant separated by one idle cycle.
- Skip and wrap: last = 5, req = 8'b0001_0001.
  - Expect grant to requester 0, next to 4, then 0 again; requesters 6 and 7 are skipped.
- Watchdog: MAX_HOLD = 4, req = 8'h08 held, done never asserted.
  - Expect gnt = 8'h08 for exactly 4 cycles, a single timeout pulse coincident with gnt = 0, then a re-grant to 3 after one idle cycle.
- Release priority: on the cycle hc == MAX_HOLD-1, assert done = 1.
  - Expect release with timeout = 0.
  - Separately, drop req[gnt_id] mid-grant: expect release on the next edge, timeout = 0.
- Reset mid-grant: gnt = 8'h20 active, pulse rst_n low between edges.
  - Expect gnt = 0, busy = 0, timeout = 0 immediately.
  - After release of reset with req = 8'hFF, expect the first grant to go to requester 0.
